// File: rtl/shift_adder.sv
// Bit-serial LSB-first adder: one full adder plus a carry flop, WIDTH shift cycles per operation.
// Define SHIFT_ADDER_ROTATE_EN to rotate the operand registers instead of zero-filling them.
module shift_adder #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] contents_a,
  output logic [WIDTH-1:0] contents_b,
  output logic [WIDTH-1:0] op,
  output logic             carry
);

  localparam int CW = $clog2(WIDTH + 1);

  logic [WIDTH-1:0] a_reg, a_next;
  logic [WIDTH-1:0] b_reg, b_next;
  logic [WIDTH-1:0] op_reg, op_next;
  logic             carry_reg, carry_next;
  logic [CW-1:0]    count_reg, count_next;

  logic [WIDTH-1:0] a_shift, b_shift;
  logic             a_fill, b_fill;
  logic             sum_bit, carry_out, busy;

`ifdef SHIFT_ADDER_ROTATE_EN
  assign a_fill = a_reg[0];
  assign b_fill = b_reg[0];
`else
  assign a_fill = 1'b0;
  assign b_fill = 1'b0;
`endif

  // Operand registers move one place toward the LSB each step.
  generate
    for (genvar gi = 0; gi < WIDTH - 1; gi++) begin : g_shift
      assign a_shift[gi] = a_reg[gi+1];
      assign b_shift[gi] = b_reg[gi+1];
    end
  endgenerate
  assign a_shift[WIDTH-1] = a_fill;
  assign b_shift[WIDTH-1] = b_fill;

  assign sum_bit   = a_reg[0] ^ b_reg[0] ^ carry_reg;
  assign carry_out = (a_reg[0] & b_reg[0]) | (a_reg[0] & carry_reg) | (b_reg[0] & carry_reg);
  assign busy      = (count_reg < CW'(WIDTH));

  always_comb begin
    a_next     = a_reg;
    b_next     = b_reg;
    op_next    = op_reg;
    carry_next = carry_reg;
    count_next = count_reg;
    if (load) begin
      a_next     = a;
      b_next     = b;
      op_next    = '0;
      carry_next = 1'b0;
      count_next = '0;
    end else if (busy) begin
      a_next     = a_shift;
      b_next     = b_shift;
      op_next    = {sum_bit, op_reg[WIDTH-1:1]};
      carry_next = carry_out;
      count_next = count_reg + CW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      a_reg     <= '0;
      b_reg     <= '0;
      op_reg    <= '0;
      carry_reg <= 1'b0;
      count_reg <= '0;
    end else begin
      a_reg     <= a_next;
      b_reg     <= b_next;
      op_reg    <= op_next;
      carry_reg <= carry_next;
      count_reg <= count_next;
    end
  end

  assign contents_a = a_reg;
  assign contents_b = b_reg;
  assign op         = op_reg;
  assign carry      = carry_reg;

endmodule

// File: tb/tb_shift_adder.sv
// Scoreboard bench for shift_adder: the driver pushes the expected register state per cycle,
// and a negedge monitor pops and compares it against the outputs.
module tb_shift_adder;
  localparam int W = 16;

  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic         load = 1'b0;
  logic [W-1:0] a = '0, b = '0;
  logic [W-1:0] contents_a, contents_b, op;
  logic         carry;

  int compared = 0;
  int mismatched = 0;

  typedef struct packed {
    logic [W-1:0] op;
    logic [W-1:0] ca;
    logic [W-1:0] cb;
    logic         c;
  } exp_t;
  exp_t q[$];

  // Model state: captured operands and number of shifts performed.
  logic [W-1:0] m_a = '0, m_b = '0;
  int           m_k = 0;

  shift_adder #(.WIDTH(W)) dut (
    .clk(clk), .reset(reset), .load(load), .a(a), .b(b),
    .contents_a(contents_a), .contents_b(contents_b), .op(op), .carry(carry)
  );

  always #5 clk = ~clk;

  // Expected state after k serial steps, from plain arithmetic on a+b.
  function automatic exp_t model(input logic [W-1:0] ma, input logic [W-1:0] mb, input int k);
    exp_t         e;
    logic [W:0]   s, m, lo;
    logic [W-1:0] sw;
    s  = {1'b0, ma} + {1'b0, mb};
    m  = ({{W{1'b0}}, 1'b1} << k) - 1'b1;
    lo = ({1'b0, ma} & m) + ({1'b0, mb} & m);
    sw = s[W-1:0];
    e.op = sw << (W - k);
    e.c  = lo[k];
`ifdef SHIFT_ADDER_ROTATE_EN
    e.ca = (ma >> k) | (ma << (W - k));
    e.cb = (mb >> k) | (mb << (W - k));
`else
    e.ca = ma >> k;
    e.cb = mb >> k;
`endif
    return e;
  endfunction

  task automatic step(input logic rst, input logic ld, input logic [W-1:0] na, input logic [W-1:0] nb);
    reset = rst;
    load  = ld;
    a     = na;
    b     = nb;
    @(posedge clk);
    if (rst) begin
      m_a = '0; m_b = '0; m_k = 0;
    end else if (ld) begin
      m_a = na; m_b = nb; m_k = 0;
      $display("load a=%h b=%h expect sum=%h", na, nb, {1'b0, na} + {1'b0, nb});
    end else if (m_k < W) begin
      m_k++;
    end
    q.push_back(model(m_a, m_b, m_k));
    #1;
  endtask

  task automatic shifts(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, $urandom, $urandom);
  endtask

  task automatic check_const(input string name, input logic [W-1:0] eop, input logic ec,
                             input logic [W-1:0] eca, input logic [W-1:0] ecb);
    @(negedge clk);
    #1;
    compared++;
    if (op !== eop || carry !== ec || contents_a !== eca || contents_b !== ecb) begin
      mismatched++;
      $display("FAIL %s: got op=%h carry=%b ca=%h cb=%h, required op=%h carry=%b ca=%h cb=%h",
               name, op, carry, contents_a, contents_b, eop, ec, eca, ecb);
    end
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (q.size() > 0) begin
      e = q.pop_front();
      compared++;
      if (op !== e.op || carry !== e.c || contents_a !== e.ca || contents_b !== e.cb) begin
        mismatched++;
        $display("FAIL state t=%0t: got op=%h carry=%b ca=%h cb=%h, required op=%h carry=%b ca=%h cb=%h",
                 $time, op, carry, contents_a, contents_b, e.op, e.c, e.ca, e.cb);
      end
    end
  end

  initial begin
    logic [W-1:0] ra, rb, ea1, eb1;
    step(1'b1, 1'b0, '0, '0);
    step(1'b1, 1'b0, '0, '0);
    check_const("reset", '0, 1'b0, '0, '0);
    shifts(20);
    check_const("idle_zero", '0, 1'b0, '0, '0);

`ifdef SHIFT_ADDER_ROTATE_EN
    ea1 = 16'h1234; eb1 = 16'h83A9;
`else
    ea1 = '0; eb1 = '0;
`endif
    step(1'b0, 1'b1, 16'h1234, 16'h83A9);
    shifts(16);
    check_const("basic", 16'h95DD, 1'b0, ea1, eb1);
    shifts(3);
    check_const("basic_hold", 16'h95DD, 1'b0, ea1, eb1);

    step(1'b0, 1'b1, 16'hFFFF, 16'h0001);
    shifts(1);
`ifdef SHIFT_ADDER_ROTATE_EN
    check_const("ovf_1shift", 16'h0000, 1'b1, 16'hFFFF, 16'h8000);
`else
    check_const("ovf_1shift", 16'h0000, 1'b1, 16'h7FFF, 16'h0000);
`endif
    shifts(15);
    check_const("ovf_wrap", 16'h0000, 1'b1, 16'hFFFF & {W{ea1 != 0}}, 16'h0001 & {W{ea1 != 0}});

    step(1'b0, 1'b1, 16'h8000, 16'h8000);
    shifts(16);
    check_const("msb_carry", 16'h0000, 1'b1, 16'h8000 & {W{ea1 != 0}}, 16'h8000 & {W{ea1 != 0}});

    step(1'b0, 1'b1, 16'h00FF, 16'h0F0F);
    shifts(5);
    step(1'b0, 1'b1, 16'h0003, 16'h0004);
    shifts(16);
    check_const("reload", 16'h0007, 1'b0, 16'h0003 & {W{ea1 != 0}}, 16'h0004 & {W{ea1 != 0}});

    step(1'b0, 1'b1, 16'hAAAA, 16'h5555);
    shifts(8);
    step(1'b1, 1'b0, '0, '0);
    check_const("mid_reset", '0, 1'b0, '0, '0);
    shifts(18);
    check_const("post_reset", '0, 1'b0, '0, '0);

    // Randomised operations, including held loads, aborts and resets.
    for (int t = 0; t < 40; t++) begin
      ra = $urandom;
      rb = $urandom;
      case ($urandom_range(0, 5))
        0: ra = 16'hFFFF;
        1: rb = 16'h0000;
        2: begin ra = 16'h8000; rb = $urandom | 16'h8000; end
        default: ;
      endcase
      for (int h = 0; h < int'($urandom_range(1, 3)); h++) step(1'b0, 1'b1, ra, rb);
      if ($urandom_range(0, 7) == 0) begin
        shifts($urandom_range(0, 10));
        step(1'b1, $urandom_range(0, 1) == 1, $urandom, $urandom);
      end
      shifts($urandom_range(0, 20));
    end

    repeat (2) @(negedge clk);
    #1;
    compared++;
    if (q.size() != 0) begin
      mismatched++;
      $display("FAIL drain: got %0d pending entries, required 0", q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
